lsq_dcache_sched: RTL and testbench

- In-order load/store scheduler between the RAS allocation interface and the dcache datapath port.
- Buffers memory ops in a circular queue and issues the head entry to the dcache one at a time.
- Loads issue as soon as they reach the head. Stores issue only when the ROB reports the store's tag at retirement.
- Returns completions to the ROB and flushes everything on an ROB resteer.

---
 rtl/lsq_pkg.sv | 27 ++
 rtl/lsq_fifo.sv | 56 +++++
 rtl/lsq_dcache_sched.sv | 136 +++++++++++++
 tb/tb_lsq_dcache_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types for the load/store dcache scheduler:
// FSM states, access sizes and the queue entry layout.
package lsq_pkg;

    // Entry tag storage; must be at least as wide as the rename tag.
    localparam int LSQ_TAG_MAX = 16;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DRAIN
    } lsq_state_e;

    typedef struct packed {
        logic [31:0]            addr;
        logic [31:0]            data;
        logic [1:0]             size;
        logic                   is_st;
        logic [LSQ_TAG_MAX-1:0] tag;
    } lsq_entry_t;

endpackage

// File: rtl/lsq_fifo.sv
// Circular entry buffer for the scheduler.
// Flush wins over push/pop; push is refused while full.
module lsq_fifo
    import lsq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  lsq_entry_t               push_entry,
    input  logic                     pop,
    output lsq_entry_t               head_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    lsq_entry_t    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full && !flush;
    assign do_pop     = pop && !empty && !flush;
    assign head_entry = mem[head];

    // Pointer and occupancy update; pointers wrap at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_entry;
    end

endmodule

// File: rtl/lsq_dcache_sched.sv
// In-order load/store scheduler: queues ops, issues the head to
// the dcache one at a time, gates stores on ROB retirement.
module lsq_dcache_sched
    import lsq_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 8,
    parameter int OOO_TAG_SIZE = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ls_unit_alloc,
    input  logic [31:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic [1:0]              size_in,
    input  logic                    is_st_in,
    input  logic [OOO_TAG_SIZE-1:0] ooo_tag_in,
    output logic                    lsq_full,
    input  logic [OOO_TAG_SIZE-1:0] rob_ret_tag_in,
    input  logic                    rob_valid,
    input  logic                    rob_resteer,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic [31:0]             dc_req_addr,
    output logic [31:0]             dc_req_data,
    output logic [1:0]              dc_req_size,
    output logic                    dc_req_is_st,
    input  logic                    dc_resp_valid,
    input  logic [31:0]             dc_resp_data,
    output logic                    out_valid,
    output logic [OOO_TAG_SIZE-1:0] out_tag,
    output logic [31:0]             out_data,
    output logic                    out_is_st,
    output logic                    ls_unit_empty
);

    lsq_state_e                    state;
    lsq_state_e                    state_nxt;
    lsq_entry_t                    alloc_entry;
    lsq_entry_t                    head_entry;
    logic [$clog2(QUEUE_DEPTH):0]  count;
    logic                          q_empty;
    logic                          push;
    logic                          pop;
    logic                          rob_match;
    logic                          head_issuable;

    assign alloc_entry = '{
        addr:  addr_in,
        data:  data_in,
        size:  size_in,
        is_st: is_st_in,
        tag:   LSQ_TAG_MAX'(ooo_tag_in)
    };

    assign push = ls_unit_alloc && !rob_resteer;

    lsq_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (rob_resteer),
        .push       (push),
        .push_entry (alloc_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
        .full       (lsq_full),
        .empty      (q_empty)
    );

    assign rob_match     = rob_valid &&
                           (head_entry.tag == LSQ_TAG_MAX'(rob_ret_tag_in));
    assign head_issuable = !q_empty && (!head_entry.is_st || rob_match);

    assign dc_req_addr   = head_entry.addr;
    assign dc_req_data   = head_entry.data;
    assign dc_req_size   = head_entry.size;
    assign dc_req_is_st  = head_entry.is_st;
    assign ls_unit_empty = (count == '0) && (state == IDLE);

    // Issue FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, request valid and pop; resteer overrides everything.
    // Valid is also masked during a resteer so a withdrawn request
    // can never be accepted on the flush cycle itself.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        dc_req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rob_resteer && head_issuable) state_nxt = REQ;
            end
            REQ: begin
                dc_req_valid = !rob_resteer;
                if (rob_resteer)       state_nxt = IDLE;
                else if (dc_req_ready) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (rob_resteer) begin
                    state_nxt = dc_resp_valid ? IDLE : DRAIN;
                end else if (dc_resp_valid) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (dc_resp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Completion register: one-cycle pulse per popped entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
            out_is_st <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                out_tag   <= head_entry.tag[OOO_TAG_SIZE-1:0];
                out_is_st <= head_entry.is_st;
                out_data  <= head_entry.is_st ? 32'd0 : dc_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_lsq_dcache_sched.sv
// Directed bench for lsq_dcache_sched: load/store paths,
// full/wrap, backpressure and resteer corner cases.
module tb_lsq_dcache_sched;
    import lsq_pkg::*;

    logic        clk;
    logic        rst;
    logic        ls_unit_alloc;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  size_in;
    logic        is_st_in;
    logic [9:0]  ooo_tag_in;
    logic        lsq_full;
    logic [9:0]  rob_ret_tag_in;
    logic        rob_valid;
    logic        rob_resteer;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_data;
    logic [1:0]  dc_req_size;
    logic        dc_req_is_st;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_data;
    logic        out_valid;
    logic [9:0]  out_tag;
    logic [31:0] out_data;
    logic        out_is_st;
    logic        ls_unit_empty;

    int n_tests = 0;
    int n_fail  = 0;

    lsq_dcache_sched #(
        .QUEUE_DEPTH  (8),
        .OOO_TAG_SIZE (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ls_unit_alloc  (ls_unit_alloc),
        .addr_in        (addr_in),
        .data_in        (data_in),
        .size_in        (size_in),
        .is_st_in       (is_st_in),
        .ooo_tag_in     (ooo_tag_in),
        .lsq_full       (lsq_full),
        .rob_ret_tag_in (rob_ret_tag_in),
        .rob_valid      (rob_valid),
        .rob_resteer    (rob_resteer),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_size    (dc_req_size),
        .dc_req_is_st   (dc_req_is_st),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .out_valid      (out_valid),
        .out_tag        (out_tag),
        .out_data       (out_data),
        .out_is_st      (out_is_st),
        .ls_unit_empty  (ls_unit_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_op(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input logic st,
                            input logic [9:0] tg);
        ls_unit_alloc = 1'b1;
        addr_in       = a;
        data_in       = d;
        size_in       = sz;
        is_st_in      = st;
        ooo_tag_in    = tg;
        tick();
        ls_unit_alloc = 1'b0;
    endtask

    // Waits (bounded) for a request, accepts it, returns a response.
    task automatic serve(input logic [9:0] tg, input logic [31:0] a,
                         input logic [31:0] rdata);
        int n = 0;
        while (!dc_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", dc_req_valid, 1);
        if (dc_req_valid) begin
            chk("req_addr", dc_req_addr, a);
            dc_req_ready = 1'b1;
            tick();
            dc_req_ready = 1'b0;
            chk("one_accept", dc_req_valid, 0);
            dc_resp_valid = 1'b1;
            dc_resp_data  = rdata;
            tick();
            dc_resp_valid = 1'b0;
            chk("srv_out_valid", out_valid, 1);
            chk("srv_out_tag", out_tag, tg);
            chk("srv_out_data", out_data, rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        rst            = 1'b1;
        ls_unit_alloc  = 1'b0;
        addr_in        = '0;
        data_in        = '0;
        size_in        = SZ_WORD;
        is_st_in       = 1'b0;
        ooo_tag_in     = '0;
        rob_ret_tag_in = '0;
        rob_valid      = 1'b0;
        rob_resteer    = 1'b0;
        dc_req_ready   = 1'b0;
        dc_resp_valid  = 1'b0;
        dc_resp_data   = '0;
        tick();
        tick();
        chk("rst_full", lsq_full, 0);
        chk("rst_empty", ls_unit_empty, 1);
        chk("rst_req_valid", dc_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_is_st", out_is_st, 0);
        rst = 1'b0;
        tick();

        // Load path with minimum latency.
        alloc_op(32'h100, 32'h0, SZ_WORD, 1'b0, 10'd5);
        chk("ld_not_yet", dc_req_valid, 0);
        dc_req_ready = 1'b1;
        tick();
        chk("ld_req_valid", dc_req_valid, 1);
        chk("ld_req_addr", dc_req_addr, 32'h100);
        chk("ld_req_is_st", dc_req_is_st, 0);
        tick();
        dc_req_ready = 1'b0;
        chk("ld_req_done", dc_req_valid, 0);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'hDEADBEEF;
        tick();
        dc_resp_valid = 1'b0;
        chk("ld_out_valid", out_valid, 1);
        chk("ld_out_tag", out_tag, 5);
        chk("ld_out_data", out_data, 32'hDEADBEEF);
        chk("ld_out_is_st", out_is_st, 0);
        tick();
        chk("ld_out_pulse", out_valid, 0);
        chk("ld_empty", ls_unit_empty, 1);

        // Store waits for its tag at retirement.
        rob_valid      = 1'b1;
        rob_ret_tag_in = 10'd6;
        alloc_op(32'h200, 32'h55AA, SZ_HALF, 1'b1, 10'd7);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bad |= dc_req_valid;
            tick();
        end
        chk("st_gated", bad, 0);
        rob_ret_tag_in = 10'd7;
        tick();
        rob_valid = 1'b0;
        chk("st_req_valid", dc_req_valid, 1);
        chk("st_req_data", dc_req_data, 32'h55AA);
        chk("st_req_is_st", dc_req_is_st, 1);
        chk("st_req_size", dc_req_size, SZ_HALF);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'h12345678;
        tick();
        dc_resp_valid = 1'b0;
        chk("st_out_valid", out_valid, 1);
        chk("st_out_tag", out_tag, 7);
        chk("st_out_is_st", out_is_st, 1);
        chk("st_out_data", out_data, 0);
        tick();

        // Fill to full, drop one extra, hold under backpressure.
        ls_unit_alloc = 1'b1;
        is_st_in      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_in    = 32'h1000 + 32'(4 * i);
            ooo_tag_in = 10'(i);
            tick();
        end
        ls_unit_alloc = 1'b0;
        chk("full_after8", lsq_full, 1);
        alloc_op(32'h9999, 32'h0, SZ_WORD, 1'b0, 10'd99);
        chk("full_after9", lsq_full, 1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bad |= !dc_req_valid || (dc_req_addr != 32'h1000) ||
                   dc_req_is_st;
            tick();
        end
        chk("bp_hold", bad, 0);
        for (int i = 0; i < 8; i++) begin
            serve(10'(i), 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            if (i == 0) chk("not_full", lsq_full, 0);
        end
        chk("drop9_empty", ls_unit_empty, 1);

        // Second batch wraps around the buffer.
        ls_unit_alloc = 1'b1;
        for (int i = 8; i < 16; i++) begin
            addr_in    = 32'h2000 + 32'(4 * i);
            ooo_tag_in = 10'(i);
            tick();
        end
        ls_unit_alloc = 1'b0;
        chk("wrap_full", lsq_full, 1);
        for (int i = 8; i < 16; i++) begin
            serve(10'(i), 32'h2000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        end
        chk("wrap_empty", ls_unit_empty, 1);

        // Resteer while waiting on a response: drain then recover.
        for (int i = 0; i < 3; i++) begin
            alloc_op(32'h300 + 32'(4 * i), 32'h0, SZ_WORD, 1'b0, 10'(20 + i));
        end
        chk("rs_req_valid", dc_req_valid, 1);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        rob_resteer  = 1'b1;
        tick();
        rob_resteer = 1'b0;
        chk("rs_drain_busy", ls_unit_empty, 0);
        alloc_op(32'h400, 32'h0, SZ_WORD, 1'b0, 10'd30);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bad |= dc_req_valid || out_valid;
            tick();
        end
        chk("rs_drain_quiet", bad, 0);
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'hBAD0BAD0;
        tick();
        dc_resp_valid = 1'b0;
        chk("rs_discard", out_valid, 0);
        serve(10'd30, 32'h400, 32'hC0DE0030);
        chk("rs_empty", ls_unit_empty, 1);

        // Resteer coincident with alloc and response.
        alloc_op(32'h500, 32'h0, SZ_WORD, 1'b0, 10'd40);
        tick();
        chk("co_req_valid", dc_req_valid, 1);
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        dc_resp_data  = 32'hFACEFACE;
        rob_resteer   = 1'b1;
        ls_unit_alloc = 1'b1;
        addr_in       = 32'h504;
        ooo_tag_in    = 10'd41;
        tick();
        dc_resp_valid = 1'b0;
        rob_resteer   = 1'b0;
        ls_unit_alloc = 1'b0;
        chk("co_out_valid", out_valid, 0);
        chk("co_empty", ls_unit_empty, 1);
        tick();
        chk("co_no_req", dc_req_valid, 0);
        chk("co_no_out", out_valid, 0);

        // Resteer withdraws a pending request without ready.
        alloc_op(32'h600, 32'h0, SZ_WORD, 1'b0, 10'd50);
        tick();
        chk("wd_req_valid", dc_req_valid, 1);
        rob_resteer = 1'b1;
        tick();
        rob_resteer = 1'b0;
        chk("wd_withdrawn", dc_req_valid, 0);
        chk("wd_empty", ls_unit_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
